// File: rtl/fetch_byte_queue.sv
// Fetch byte queue: line requests to the I-cache, 16-byte circular buffer, 5-byte window to IF/ID.
// Optional starvation counter enabled by defining FETCH_BYTE_QUEUE_PERF_EN.
module fetch_byte_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QBYTES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_gnt,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  input  logic [2:0]  len_in,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [39:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic [2:0]  instr_length_out
`ifdef FETCH_BYTE_QUEUE_PERF_EN
  ,
  output logic [15:0] perf_starve_cnt
`endif
);

  localparam int PW = $clog2(QBYTES);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] REQ_MAX = CW'(QBYTES - 8);

  logic [7:0]    queue_q [QBYTES];
  logic [7:0]    queue_d [QBYTES];
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    skip_q, skip_d;
  logic          out_q, out_d;
  logic          drop_q, drop_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   pc_q, pc_d;

  logic          len_ok;
  logic          consume;
  logic          append;
  logic [PW-1:0] tail;
  logic [PW-1:0] wr_idx;

  always_comb begin
    instr_out = '0;
    for (int i = 0; i < 5; i++) begin
      if (CW'(i) < count_q) instr_out[8*i +: 8] = queue_q[head_q + PW'(i)];
    end
  end

  assign len_ok           = (len_in != 3'd0) && (len_in <= 3'd5);
  assign instr_valid      = (count_q != '0) && len_ok && (count_q >= CW'(len_in));
  assign consume          = instr_valid && !stall && !redirect;
  assign append           = resp_valid && !drop_q && !redirect;
  assign fetch_req        = !out_q && (count_q <= REQ_MAX) && !redirect;
  assign instr_length_out = instr_valid ? len_in : 3'd0;
  assign fetch_addr       = fetch_addr_q;
  assign pc_out           = pc_q;
  assign tail             = head_q + count_q[PW-1:0];

  always_comb begin
    queue_d      = queue_q;
    head_d       = head_q;
    count_d      = count_q;
    skip_d       = skip_q;
    out_d        = out_q;
    drop_d       = drop_q;
    fetch_addr_d = fetch_addr_q;
    pc_d         = pc_q;
    wr_idx       = '0;
    if (redirect) begin
      // an in-flight line belongs to the old stream; mark it for discard
      count_d      = '0;
      pc_d         = redirect_pc;
      fetch_addr_d = {redirect_pc[31:3], 3'b000};
      skip_d       = redirect_pc[2:0];
      drop_d       = out_q && !resp_valid;
      out_d        = out_q && !resp_valid;
    end else begin
      if (fetch_req && fetch_gnt) begin
        out_d        = 1'b1;
        fetch_addr_d = fetch_addr_q + 32'd8;
      end
      if (consume) begin
        head_d = head_q + PW'(len_in);
        pc_d   = pc_q + {29'd0, len_in};
      end
      if (resp_valid) begin
        out_d  = 1'b0;
        drop_d = 1'b0;
      end
      if (append) begin
        for (int k = 0; k < 8; k++) begin
          if (3'(k) >= skip_q) begin
            wr_idx          = tail + PW'(k) - PW'(skip_q);
            queue_d[wr_idx] = resp_data[8*k +: 8];
          end
        end
        skip_d = 3'd0;
      end
      count_d = count_q - (consume ? CW'(len_in) : '0)
                        + (append ? CW'(4'd8 - {1'b0, skip_q}) : '0);
    end
  end

  always_ff @(posedge clk) begin
    queue_q <= queue_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      count_q      <= '0;
      skip_q       <= RESET_PC[2:0];
      out_q        <= 1'b0;
      drop_q       <= 1'b0;
      fetch_addr_q <= {RESET_PC[31:3], 3'b000};
      pc_q         <= RESET_PC;
    end else begin
      head_q       <= head_d;
      count_q      <= count_d;
      skip_q       <= skip_d;
      out_q        <= out_d;
      drop_q       <= drop_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
    end
  end

`ifdef FETCH_BYTE_QUEUE_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (!instr_valid && !stall && !redirect && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_starve_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Randomized bench for fetch_byte_queue: queue-based reference model feeds scoreboards,
// a monitor compares consumed windows and granted fetch addresses.
module tb_fetch_byte_queue;

  localparam int          QB     = 16;
  localparam logic [31:0] RST_PC = 32'h0000_1003;
  localparam int          NCYC   = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt = 1'b0;
  logic        resp_valid = 1'b0;
  logic [63:0] resp_data = '0;
  logic [2:0]  len_in = 3'd1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [39:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [2:0]  instr_length_out;
`ifdef FETCH_BYTE_QUEUE_PERF_EN
  logic [15:0] perf_starve_cnt;
`endif

  fetch_byte_queue #(.RESET_PC(RST_PC), .QBYTES(QB)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .len_in(len_in), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_length_out(instr_length_out)
`ifdef FETCH_BYTE_QUEUE_PERF_EN
    , .perf_starve_cnt(perf_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [39:0] win;
    logic [2:0]  len;
  } instr_t;

  instr_t      isb[$];
  logic [31:0] rsb[$];
  int checks = 0;
  int errors = 0;

  // reference model: plain byte stream plus fetch bookkeeping
  logic [7:0]  mq[$];
  logic [31:0] m_pc, m_faddr;
  int          m_skip;
  bit          m_out, m_drop;
  int          m_perf;
  bit          c_busy;
  int          c_wait;
  logic [31:0] c_addr;

  function automatic logic [7:0] mb(input logic [31:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  function automatic logic [63:0] line(input logic [31:0] a);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = mb(a + 32'(k));
    return d;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc    = RST_PC;
    m_faddr = {RST_PC[31:3], 3'b000};
    m_skip  = int'(RST_PC[2:0]);
    m_out   = 0;
    m_drop  = 0;
    m_perf  = 0;
    c_busy  = 0;
    c_wait  = 0;
    c_addr  = '0;
  endtask

  // monitor
  initial begin
    instr_t e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (instr_valid && !stall && !redirect) begin
          if (isb.size() == 0) begin
            checks++; errors++;
            $display("FAIL consume_unexpected: got pc %0h expected no consume", pc_out);
          end else begin
            e = isb.pop_front();
            chk("pc_out", 64'(pc_out), 64'(e.pc));
            chk("instr_out", 64'(instr_out), 64'(e.win));
            chk("instr_length_out", 64'(instr_length_out), 64'(e.len));
          end
        end
        if (!instr_valid) chk("len_when_invalid", 64'(instr_length_out), 64'd0);
        if (fetch_req && fetch_gnt) begin
          if (rsb.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got addr %0h expected no request", fetch_addr);
          end else begin
            ea = rsb.pop_front();
            chk("fetch_addr", 64'(fetch_addr), 64'(ea));
          end
        end
      end
    end
  end

  // driver + model
  initial begin
    int  m_count, rel, stall_left, last_rst;
    bit  m_req, m_valid, m_cons, m_grant, forced_done;
    logic [39:0] win;
    logic [31:0] ga;
    int  r;

    model_reset();
    stall_left  = 0;
    forced_done = 0;
    last_rst    = 0;
    repeat (3) @(negedge clk);

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == 0) rst = 1'b1;
      rel = cyc - last_rst;

      // stimulus
      if (stall_left > 0) begin
        stall = 1'b1; stall_left--;
      end else begin
        stall = 1'b0;
        if ($urandom_range(0, 9) == 0) stall_left = $urandom_range(1, 4);
      end
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom;
      fetch_gnt   = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      if (r == 0) len_in = 3'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(6, 7));
      else        len_in = 3'($urandom_range(1, 5));

      if (rel < 10) begin
        stall = 1'b0; redirect = 1'b0; fetch_gnt = 1'b0; stall_left = 0;
      end else if (rel < 30) begin
        stall = 1'b0; redirect = 1'b0; fetch_gnt = 1'b1; len_in = 3'd5; stall_left = 0;
      end else if (rel == 30) begin
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2000;
      end else if (rel < 80) begin
        stall = 1'b0; redirect = 1'b0; fetch_gnt = 1'b1; len_in = 3'd2; stall_left = 0;
      end else if (!forced_done && m_out) begin
        redirect = 1'b1; redirect_pc = 32'h0000_3006; forced_done = 1;
      end

      resp_valid = c_busy && (c_wait == 0);
      resp_data  = resp_valid ? line(c_addr) : 64'($urandom);

      #1;
      m_count = mq.size();
      m_req   = !m_out && (m_count <= QB - 8) && !redirect;
      m_valid = (m_count >= 1) && (len_in >= 1) && (len_in <= 5) && (m_count >= int'(len_in));
      m_cons  = m_valid && !stall && !redirect;
      m_grant = m_req && fetch_gnt;
      if (m_cons) begin
        win = '0;
        for (int i = 0; i < 5; i++) if (i < m_count) win[8*i +: 8] = mq[i];
        isb.push_back('{pc: m_pc, win: win, len: len_in});
      end
      if (m_grant) rsb.push_back(m_faddr);
      if (!m_valid && !stall && !redirect && m_perf != 65535) m_perf++;

      if (rel == 0) begin
        chk("rst_fetch_req", 64'(fetch_req), 64'd1);
        chk("rst_fetch_addr", 64'(fetch_addr), 64'h1000);
        chk("rst_pc_out", 64'(pc_out), 64'(RST_PC));
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr_out", 64'(instr_out), 64'd0);
      end
`ifdef FETCH_BYTE_QUEUE_PERF_EN
      if (rel == 10) chk("perf_after_10_empty", 64'(perf_starve_cnt), 64'd10);
`endif

      @(posedge clk);
      ga = m_faddr;
      if (redirect) begin
        mq.delete();
        m_pc    = redirect_pc;
        m_faddr = {redirect_pc[31:3], 3'b000};
        m_skip  = int'(redirect_pc[2:0]);
        m_drop  = m_out && !resp_valid;
        m_out   = m_out && !resp_valid;
      end else begin
        if (m_grant) begin
          m_out   = 1;
          m_faddr = m_faddr + 32'd8;
        end
        if (m_cons) begin
          for (int i = 0; i < int'(len_in); i++) void'(mq.pop_front());
          m_pc = m_pc + 32'(len_in);
        end
        if (resp_valid) begin
          m_out = 0;
          if (m_drop) m_drop = 0;
          else begin
            for (int k = m_skip; k < 8; k++) mq.push_back(resp_data[8*k +: 8]);
            m_skip = 0;
          end
        end
      end
      if (resp_valid) c_busy = 0;
      else if (c_busy) c_wait--;
      if (m_grant) begin
        c_busy = 1;
        c_addr = ga;
        c_wait = $urandom_range(0, 3);
      end

      if (cyc == 1999) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        last_rst    = cyc + 1;
        forced_done = 0;
      end
    end

    @(negedge clk);
    #3;
    chk("isb_drained", 64'(isb.size()), 64'd0);
    chk("rsb_drained", 64'(rsb.size()), 64'd0);
`ifdef FETCH_BYTE_QUEUE_PERF_EN
    chk("perf_final", 64'(perf_starve_cnt), 64'(m_perf));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
